imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH, 64, number of 32-bit words in the instruction memory being loaded.
REQ-002 Parameter: CNT_W, 7, width of the word-count input (holds 0..DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a load session.
REQ-006 abort  input  1  cancels the session in progress.
REQ-007 num_words  input  CNT_W  words to load this session; sampled on accepted start.
REQ-008 byte_valid  input  1  byte_data is valid.
REQ-009 byte_data  input  8  program byte stream, little-endian per word.
REQ-010 byte_ready  output  1  loader accepts a byte this cycle.
REQ-011 mem_we  output  1  one-cycle write strobe to the instruction memory.
REQ-012 mem_addr  output  32  byte address of the written word; bits [1:0] are always 0.
REQ-013 mem_wdata  output  32  assembled instruction word.
REQ-014 busy  output  1  session active; also used to hold the core in reset.
REQ-015 done  output  1  level; last session completed normally.
REQ-016 err  output  1  level; last start was rejected.

Function
REQ-017 FSM states: IDLE, LOAD, WRITE, DONE.
REQ-018 IDLE: start with 1 <= num_words <= DEPTH -> LOAD; clear done, err, word counter, and byte index; set address to 0.
REQ-019 IDLE: start with num_words == 0 or num_words > DEPTH -> stay IDLE and set err=1.
REQ-020 DONE behaves as IDLE for start; otherwise DONE holds done=1.
REQ-021 A byte transfers only when byte_valid && byte_ready; byte_ready=1 only in LOAD.
REQ-022 The k-th byte of a word (k=0..3) is placed in mem_wdata[8k+7:8k].
REQ-023 The transfer of byte 3 moves LOAD -> WRITE.
REQ-024 WRITE lasts exactly one cycle: mem_we=1 with mem_addr = 4*word_index and mem_wdata = the assembled word.
REQ-025 Latency: mem_we is asserted in the cycle immediately after the 4th byte handshake.
REQ-026 After WRITE: increment word_index; go to DONE if word_index+1 == num_words, else return to LOAD.
REQ-027 DONE asserts done=1 and busy=0.
REQ-028 busy=1 in LOAD and WRITE only.
REQ-029 start is ignored while busy=1.
REQ-030 byte_valid without byte_ready does not change state; the byte is held by the source.
REQ-031 abort in LOAD or WRITE -> IDLE next cycle, discarding any partial word.
REQ-032 If abort coincides with WRITE, the write still occurs that cycle.
REQ-033 An aborted session leaves done=0 and err=0.
REQ-034 abort has priority over a simultaneous byte handshake.
REQ-035 mem_addr never exceeds 4*(DEPTH-1); the address never wraps.

Reset
REQ-036 rst_n low immediately forces state=IDLE and byte_ready, mem_we, busy, done, err = 0.
REQ-037 rst_n low also clears mem_addr and mem_wdata to 0 and zeroes all counters.
REQ-038 Reset during a session discards the partial word; no mem_we pulse follows reset release.

Structure
REQ-039 Shared package: FSM state encoding, DEPTH default, and word/byte width constants (32, 8).
REQ-040 Sub-module byte_packer: holds byte index and shift register, and flags word completion; the FSM and counters stay in imem_loader.

Verification
REQ-041 Normal load: start, num_words=2, bytes 13,00,00,00,B3,05,00,00 -> writes 0x00000013 @0x0 and 0x000005B3 @0x4, then done=1, busy=0.
REQ-042 Backpressure: byte_valid toggled randomly -> same writes; no byte lost or duplicated.
REQ-043 Reject: start with num_words=0, and separately with 65 -> err=1, busy=0, no mem_we.
REQ-044 Abort: abort after 6 bytes of a 2-word load -> exactly one write (@0x0), then IDLE, done=0; a new load restarts at address 0.
REQ-045 Reset mid-word: rst_n low after 2 bytes -> all outputs 0 immediately; no write after release.
REQ-046 Full depth: num_words=64 -> last write @0xFC, done=1, start ignored throughout busy.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds the FSM state encoding and the word/byte geometry.
package imem_loader_pkg;

   localparam int DEPTH_DEF      = 64;
   localparam int WORD_W         = 32;
   localparam int BYTE_W         = 8;
   localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
   localparam int BIDX_W         = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles a little-endian byte stream into 32-bit words.
// Flags the cycle in which the last byte of a word is accepted.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              byte_en,
   input  logic [BYTE_W-1:0] byte_data,
   output logic [WORD_W-1:0] word,
   output logic              word_full
);

   logic [BIDX_W-1:0] byte_idx;

   // Shifting in from the top lands byte k at bits [8k+7:8k] after four bytes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_idx <= '0;
         word     <= '0;
      end else if (clear) begin
         byte_idx <= '0;
         word     <= '0;
      end else if (byte_en) begin
         byte_idx <= byte_idx + BIDX_W'(1);
         word     <= {byte_data, word[WORD_W-1:BYTE_W]};
      end
   end

   assign word_full = byte_en && (byte_idx == BIDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory one word at a time.
// state | meaning
// IDLE  | waiting for start; err reports the last rejected start
// LOAD  | accepting bytes of the current word
// WRITE | one-cycle write strobe of the assembled word
// DONE  | session completed; waiting for start
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] num_words,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic             byte_ready,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] num_q;
   logic [CNT_W-1:0] word_idx;
   logic             idle_like;
   logic             start_ok;
   logic             start_acc;
   logic             start_rej;
   logic             last_word;
   logic             byte_en;
   logic             word_full;
   logic             pk_clear;
   logic [WORD_W-1:0] pk_word;

   assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
   assign start_ok  = (num_words != '0) && (num_words <= DEPTH_C);
   assign start_acc = idle_like && start && start_ok;
   assign start_rej = idle_like && start && !start_ok;
   assign last_word = ((word_idx + CNT_W'(1)) == num_q);
   assign byte_en   = byte_valid && byte_ready;
   assign pk_clear  = start_acc || (abort && busy);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE: if (start_acc) state_nxt = ST_LOAD;
         ST_LOAD: begin
            if (abort)          state_nxt = ST_IDLE;
            else if (word_full) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            if (abort)          state_nxt = ST_IDLE;
            else if (last_word) state_nxt = ST_DONE;
            else                state_nxt = ST_LOAD;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Gating byte_ready with abort keeps an aborting cycle from consuming a byte.
   always_comb begin
      byte_ready = (state == ST_LOAD) && !abort;
      mem_we     = (state == ST_WRITE);
      busy       = (state == ST_LOAD) || (state == ST_WRITE);
      done       = (state == ST_DONE);
   end

   // The last word leaves word_idx in place so the address never passes the top word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_q    <= '0;
         word_idx <= '0;
         err      <= 1'b0;
      end else begin
         if (start_acc) begin
            num_q    <= num_words;
            word_idx <= '0;
            err      <= 1'b0;
         end else if (start_rej) begin
            err <= 1'b1;
         end else if (busy && abort) begin
            word_idx <= '0;
         end else if ((state == ST_WRITE) && !last_word) begin
            word_idx <= word_idx + CNT_W'(1);
         end
      end
   end

   assign mem_addr  = {{(32 - CNT_W - 2){1'b0}}, word_idx, 2'b00};
   assign mem_wdata = pk_word;

   byte_packer u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (pk_clear),
      .byte_en   (byte_en),
      .byte_data (byte_data),
      .word      (pk_word),
      .word_full (word_full)
   );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: vector table for a plain load, then
// hand-written sequences for backpressure, reject, abort, reset and full depth.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [6:0]  num_words;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        busy;
   logic        done;
   logic        err;

   imem_loader #(.DEPTH(64), .CNT_W(7)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .num_words  (num_words),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int busy_drops = 0;
   bit hold_start = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;
   wr_t wq[$];
   logic [7:0] bq[$];

   // flags = {byte_ready, mem_we, busy, done, err}
   typedef struct {
      logic        st;
      logic        ab;
      logic [6:0]  nw;
      logic        bv;
      logic [7:0]  bd;
      logic [4:0]  flags;
      logic [31:0] addr;
      logic [31:0] wdata;
   } vec_t;
   vec_t vecs[13];

   always @(negedge clk) if (mem_we === 1'b1) wq.push_back('{mem_addr, mem_wdata});

   function automatic vec_t mk(logic st, logic ab, logic [6:0] nw, logic bv, logic [7:0] bd,
                               logic [4:0] flags, logic [31:0] addr, logic [31:0] wdata);
      vec_t v;
      v.st = st; v.ab = ab; v.nw = nw; v.bv = bv; v.bd = bd;
      v.flags = flags; v.addr = addr; v.wdata = wdata;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
   endtask

   function automatic logic [31:0] flags_now();
      return 32'({byte_ready, mem_we, busy, done, err});
   endfunction

   task automatic check_all_zero(input string name);
      check({name, "_flags"}, flags_now(), 32'h0);
      check({name, "_addr"}, mem_addr, 32'h0);
      check({name, "_wdata"}, mem_wdata, 32'h0);
   endtask

   task automatic pulse_start(input logic [6:0] n);
      @(negedge clk);
      start = 1'b1; num_words = n; byte_valid = 1'b0; abort = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bp);
      bit got = 0;
      for (int t = 0; t < 100 && !got; t++) begin
         @(negedge clk);
         byte_data  = b;
         byte_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         start      = hold_start;
         if (hold_start) num_words = 7'd1;
         #1;
         if (hold_start && busy !== 1'b1) busy_drops++;
         if (byte_valid && byte_ready) got = 1;
      end
      if (!got) begin
         n_total++;
         $display("FAIL byte_timeout: byte 0x%02h not accepted, want accepted", b);
      end
   endtask

   task automatic load_bytes(input bit bp);
      foreach (bq[i]) send_byte(bq[i], bp);
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int t = 0; t < 50 && done !== 1'b1; t++) @(negedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_words = '0;
      byte_valid = 1'b0; byte_data = '0;
      #12;
      check_all_zero("reset");
      @(negedge clk) rst_n = 1'b1;

      // Plain two-word load, one cycle per row.
      vecs[0]  = mk(1, 0, 7'd2, 0, 8'h00, 5'b00000, 32'h0, 32'h0);
      vecs[1]  = mk(0, 0, 7'd2, 1, 8'h13, 5'b10100, 32'h0, 32'h0);
      vecs[2]  = mk(0, 0, 7'd2, 1, 8'h00, 5'b10100, 32'h0, 32'h0);
      vecs[3]  = mk(0, 0, 7'd2, 1, 8'h00, 5'b10100, 32'h0, 32'h0);
      vecs[4]  = mk(0, 0, 7'd2, 1, 8'h00, 5'b10100, 32'h0, 32'h0);
      vecs[5]  = mk(0, 0, 7'd2, 0, 8'h00, 5'b01100, 32'h0, 32'h00000013);
      vecs[6]  = mk(0, 0, 7'd2, 1, 8'hB3, 5'b10100, 32'h0, 32'h0);
      vecs[7]  = mk(0, 0, 7'd2, 1, 8'h05, 5'b10100, 32'h0, 32'h0);
      vecs[8]  = mk(0, 0, 7'd2, 1, 8'h00, 5'b10100, 32'h0, 32'h0);
      vecs[9]  = mk(0, 0, 7'd2, 1, 8'h00, 5'b10100, 32'h0, 32'h0);
      vecs[10] = mk(0, 0, 7'd2, 0, 8'h00, 5'b01100, 32'h4, 32'h000005B3);
      vecs[11] = mk(0, 0, 7'd2, 0, 8'h00, 5'b00010, 32'h0, 32'h0);
      vecs[12] = mk(0, 0, 7'd2, 0, 8'h00, 5'b00010, 32'h0, 32'h0);
      wq.delete();
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         start = vecs[i].st; abort = vecs[i].ab; num_words = vecs[i].nw;
         byte_valid = vecs[i].bv; byte_data = vecs[i].bd;
         #1;
         check($sformatf("vec%0d_flags", i), flags_now(), 32'(vecs[i].flags));
         if (vecs[i].flags[3]) begin
            check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].addr);
            check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].wdata);
         end
      end
      idle_cycle();
      check("vec_write_count", 32'(wq.size()), 32'd2);

      // Same load under random backpressure, started from DONE.
      wq.delete();
      pulse_start(7'd2);
      check("bp_busy", 32'(busy), 32'd1);
      bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h05, 8'h00, 8'h00};
      load_bytes(1);
      idle_cycle();
      wait_done();
      check("bp_count", 32'(wq.size()), 32'd2);
      if (wq.size() == 2) begin
         check("bp_w0_addr", wq[0].a, 32'h0);
         check("bp_w0_data", wq[0].d, 32'h00000013);
         check("bp_w1_addr", wq[1].a, 32'h4);
         check("bp_w1_data", wq[1].d, 32'h000005B3);
      end
      check("bp_done_flags", flags_now(), 32'b00010);

      // Rejected starts.
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      wq.delete();
      pulse_start(7'd0);
      check("rej0_flags", flags_now(), 32'b00001);
      pulse_start(7'd65);
      check("rej65_flags", flags_now(), 32'b00001);
      repeat (3) idle_cycle();
      check("rej_no_write", 32'(wq.size()), 32'd0);
      pulse_start(7'd1);
      check("accept_clears_err", flags_now(), 32'b10100);
      @(negedge clk) abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      #1 check("abort_idle_flags", flags_now(), 32'b00000);

      // Abort after six bytes of a two-word load; abort beats a byte handshake.
      wq.delete();
      pulse_start(7'd2);
      bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h05};
      load_bytes(0);
      @(negedge clk);
      abort = 1'b1; byte_valid = 1'b1; byte_data = 8'h00;
      #1 check("abort_ready_low", 32'(byte_ready), 32'd0);
      @(negedge clk);
      abort = 1'b0; byte_valid = 1'b0;
      #1 check("abort_flags", flags_now(), 32'b00000);
      check("abort_count", 32'(wq.size()), 32'd1);
      if (wq.size() == 1) check("abort_w0_data", wq[0].d, 32'h00000013);
      wq.delete();
      pulse_start(7'd1);
      bq = '{8'h93, 8'h00, 8'h00, 8'h00};
      load_bytes(0);
      idle_cycle();
      wait_done();
      check("restart_count", 32'(wq.size()), 32'd1);
      if (wq.size() == 1) begin
         check("restart_addr", wq[0].a, 32'h0);
         check("restart_data", wq[0].d, 32'h00000093);
      end

      // Abort landing on the WRITE cycle still writes.
      wq.delete();
      pulse_start(7'd2);
      bq = '{8'h11, 8'h22, 8'h33, 8'h44};
      load_bytes(0);
      @(negedge clk);
      abort = 1'b1; byte_valid = 1'b0;
      #1 check("abortwr_we", 32'(mem_we), 32'd1);
      @(negedge clk) abort = 1'b0;
      #1 check("abortwr_flags", flags_now(), 32'b00000);
      check("abortwr_count", 32'(wq.size()), 32'd1);
      if (wq.size() == 1) begin
         check("abortwr_addr", wq[0].a, 32'h0);
         check("abortwr_data", wq[0].d, 32'h44332211);
      end

      // Reset in the middle of a word.
      wq.delete();
      pulse_start(7'd1);
      bq = '{8'hAA, 8'hBB};
      load_bytes(0);
      @(negedge clk);
      rst_n = 1'b0; byte_valid = 1'b0;
      #1 check_all_zero("midrst");
      @(negedge clk) rst_n = 1'b1;
      repeat (10) idle_cycle();
      check("midrst_no_write", 32'(wq.size()), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);

      // Full depth with start held high the whole time.
      wq.delete();
      pulse_start(7'd64);
      bq.delete();
      for (int i = 0; i < 64; i++) begin
         bq.push_back(8'(i));
         bq.push_back(8'hA5);
         bq.push_back(8'h5A);
         bq.push_back(~8'(i));
      end
      hold_start = 1;
      load_bytes(0);
      hold_start = 0;
      idle_cycle();
      wait_done();
      check("full_count", 32'(wq.size()), 32'd64);
      check("full_busy_held", 32'(busy_drops), 32'd0);
      for (int i = 0; i < 64 && i < wq.size(); i++) begin
         logic [7:0] lo;
         lo = 8'(i);
         check($sformatf("full_w%0d_addr", i), wq[i].a, 32'(4 * i));
         check($sformatf("full_w%0d_data", i), wq[i].d, {~lo, 8'h5A, 8'hA5, lo});
      end
      if (wq.size() == 64) check("full_last_addr", wq[63].a, 32'h000000FC);
      check("full_done_flags", flags_now(), 32'b00010);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench still running, want finished");
      $fatal(1, "timeout");
   end

endmodule
